// File: rtl/pipe_pkg.sv
// Shared constants and types for the generic inter-stage pipeline register.
package pipe_pkg;
  localparam int IR_W = 16;
  localparam logic [IR_W-1:0] NOP_IR_DEF = 16'hF000;
  localparam int DEF_DATA_W = 16;
  localparam int DEF_CTRL_W = 1;

  typedef enum logic [1:0] {
    OCC_EMPTY = 2'd0,
    OCC_MAIN  = 2'd1,
    OCC_FULL  = 2'd2
  } occ_e;
endpackage

// File: rtl/pipe_entry.sv
// One pipeline storage slot {valid, ir, data, ctrl}; clear wins over load.
module pipe_entry
  import pipe_pkg::*;
#(
  parameter int              PAY_W  = DEF_DATA_W,
  parameter int              CTRL_W = DEF_CTRL_W,
  parameter logic [IR_W-1:0] NOP_IR = NOP_IR_DEF
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              clear,
  input  logic              load,
  input  logic [IR_W-1:0]   in_ir,
  input  logic [PAY_W-1:0]  in_data,
  input  logic [CTRL_W-1:0] in_ctrl,
  output logic              valid,
  output logic [IR_W-1:0]   ir,
  output logic [PAY_W-1:0]  data,
  output logic [CTRL_W-1:0] ctrl
);
  logic              valid_q, valid_d;
  logic [IR_W-1:0]   ir_q, ir_d;
  logic [PAY_W-1:0]  data_q, data_d;
  logic [CTRL_W-1:0] ctrl_q, ctrl_d;

  always_comb begin
    valid_d = valid_q;
    ir_d    = ir_q;
    data_d  = data_q;
    ctrl_d  = ctrl_q;
    if (clear) begin
      // Data is left as-is on clear; only fields with side effects are scrubbed.
      valid_d = 1'b0;
      ir_d    = NOP_IR;
      ctrl_d  = '0;
    end else if (load) begin
      valid_d = 1'b1;
      ir_d    = in_ir;
      data_d  = in_data;
      ctrl_d  = in_ctrl;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      valid_q <= 1'b0;
      ir_q    <= NOP_IR;
      data_q  <= '0;
      ctrl_q  <= '0;
    end else begin
      valid_q <= valid_d;
      ir_q    <= ir_d;
      data_q  <= data_d;
      ctrl_q  <= ctrl_d;
    end
  end

  assign valid = valid_q;
  assign ir    = ir_q;
  assign data  = data_q;
  assign ctrl  = ctrl_q;
endmodule

// File: rtl/pipe_stage_reg.sv
// Generic inter-stage pipeline register with valid/ready handshake, flush-to-bubble,
// optional 2-entry skid buffer and a saturating stall-cycle counter.
module pipe_stage_reg
  import pipe_pkg::*;
#(
  parameter int              DATA_W   = DEF_DATA_W,
  parameter int              NUM_DATA = 1,
  parameter int              CTRL_W   = DEF_CTRL_W,
  parameter int              SKID     = 1,
  parameter logic [IR_W-1:0] NOP_IR   = NOP_IR_DEF,
  parameter int              CNT_W    = 8
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       flush,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic [IR_W-1:0]            in_ir,
  input  logic [NUM_DATA*DATA_W-1:0] in_data,
  input  logic [CTRL_W-1:0]          in_ctrl,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [IR_W-1:0]            out_ir,
  output logic [NUM_DATA*DATA_W-1:0] out_data,
  output logic [CTRL_W-1:0]          out_ctrl,
  output logic [CNT_W-1:0]           stall_cnt
);
  localparam int PAY_W = NUM_DATA * DATA_W;

  occ_e             occ_q, occ_d;
  logic             ready_q, ready_d;
  logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;

  logic              main_ld, main_clr, skid_ld, skid_clr, main_src_skid;
  logic              main_valid;
  logic [IR_W-1:0]   main_ir, skid_ir, main_in_ir;
  logic [PAY_W-1:0]  main_data, skid_data, main_in_data;
  logic [CTRL_W-1:0] main_ctrl, skid_ctrl, main_in_ctrl;
  logic              accept, fire;

  // Skid mode: fully registered ready. Single-entry mode: ready passes out_ready through.
  assign in_ready = (SKID != 0) ? ready_q : (ready_q & (~main_valid | out_ready));
  assign accept   = in_valid & in_ready;
  assign fire     = main_valid & out_ready;

  always_comb begin
    occ_d         = occ_q;
    main_ld       = 1'b0;
    main_clr      = 1'b0;
    skid_ld       = 1'b0;
    skid_clr      = 1'b0;
    main_src_skid = 1'b0;
    if (flush) begin
      occ_d    = OCC_EMPTY;
      main_clr = 1'b1;
      skid_clr = 1'b1;
    end else if (SKID != 0) begin
      case (occ_q)
        OCC_EMPTY: begin
          if (accept) begin
            main_ld = 1'b1;
            occ_d   = OCC_MAIN;
          end
        end
        OCC_MAIN: begin
          if (accept && fire) begin
            main_ld = 1'b1;
          end else if (accept) begin
            skid_ld = 1'b1;
            occ_d   = OCC_FULL;
          end else if (fire) begin
            main_clr = 1'b1;
            occ_d    = OCC_EMPTY;
          end
        end
        OCC_FULL: begin
          if (fire) begin
            main_ld       = 1'b1;
            main_src_skid = 1'b1;
            skid_clr      = 1'b1;
            occ_d         = OCC_MAIN;
          end
        end
        default: begin
          occ_d    = OCC_EMPTY;
          main_clr = 1'b1;
          skid_clr = 1'b1;
        end
      endcase
    end else begin
      if (accept) begin
        main_ld = 1'b1;
        occ_d   = OCC_MAIN;
      end else if (fire) begin
        main_clr = 1'b1;
        occ_d    = OCC_EMPTY;
      end
    end
    ready_d = (occ_d != OCC_FULL);
  end

  always_comb begin
    stall_cnt_d = stall_cnt_q;
    if (main_valid && !out_ready && (stall_cnt_q != {CNT_W{1'b1}})) begin
      stall_cnt_d = stall_cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      occ_q       <= OCC_EMPTY;
      ready_q     <= 1'b0;
      stall_cnt_q <= '0;
    end else begin
      occ_q       <= occ_d;
      ready_q     <= ready_d;
      stall_cnt_q <= stall_cnt_d;
    end
  end

  assign main_in_ir   = main_src_skid ? skid_ir   : in_ir;
  assign main_in_data = main_src_skid ? skid_data : in_data;
  assign main_in_ctrl = main_src_skid ? skid_ctrl : in_ctrl;

  pipe_entry #(.PAY_W(PAY_W), .CTRL_W(CTRL_W), .NOP_IR(NOP_IR)) u_main (
    .clk     (clk),
    .reset   (reset),
    .clear   (main_clr),
    .load    (main_ld),
    .in_ir   (main_in_ir),
    .in_data (main_in_data),
    .in_ctrl (main_in_ctrl),
    .valid   (main_valid),
    .ir      (main_ir),
    .data    (main_data),
    .ctrl    (main_ctrl)
  );

  generate
    if (SKID != 0) begin : g_skid
      logic skid_valid_unused;
      pipe_entry #(.PAY_W(PAY_W), .CTRL_W(CTRL_W), .NOP_IR(NOP_IR)) u_skid (
        .clk     (clk),
        .reset   (reset),
        .clear   (skid_clr),
        .load    (skid_ld),
        .in_ir   (in_ir),
        .in_data (in_data),
        .in_ctrl (in_ctrl),
        .valid   (skid_valid_unused),
        .ir      (skid_ir),
        .data    (skid_data),
        .ctrl    (skid_ctrl)
      );
    end else begin : g_noskid
      logic skid_unused;
      assign skid_unused = skid_ld ^ skid_clr;
      assign skid_ir     = NOP_IR;
      assign skid_data   = '0;
      assign skid_ctrl   = '0;
    end
  endgenerate

  // Bubble gating keeps downstream free of side effects whenever the slot is empty.
  assign out_valid = main_valid;
  assign out_ir    = main_valid ? main_ir : NOP_IR;
  assign out_ctrl  = main_valid ? main_ctrl : '0;
  assign out_data  = main_data;
  assign stall_cnt = stall_cnt_q;
endmodule

// File: tb/tb_pipe_stage_reg.sv
// Bench for pipe_stage_reg: a skid instance and a single-entry instance checked against queue models.
module tb_pipe_stage_reg;
  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic reset;

  logic        flush_a, in_valid_a, in_ready_a, out_valid_a, out_ready_a, in_ctrl_a, out_ctrl_a;
  logic [15:0] in_ir_a, out_ir_a, in_data_a, out_data_a;
  logic [7:0]  stall_cnt_a;

  logic        flush_b, in_valid_b, in_ready_b, out_valid_b, out_ready_b;
  logic [15:0] in_ir_b, out_ir_b;
  logic [31:0] in_data_b, out_data_b;
  logic [2:0]  in_ctrl_b, out_ctrl_b;
  logic [3:0]  stall_cnt_b;

  pipe_stage_reg #(.DATA_W(16), .NUM_DATA(1), .CTRL_W(1), .SKID(1), .NOP_IR(16'hF000), .CNT_W(8)) dut_a (
    .clk(clk), .reset(reset), .flush(flush_a), .in_valid(in_valid_a), .in_ready(in_ready_a),
    .in_ir(in_ir_a), .in_data(in_data_a), .in_ctrl(in_ctrl_a), .out_valid(out_valid_a),
    .out_ready(out_ready_a), .out_ir(out_ir_a), .out_data(out_data_a), .out_ctrl(out_ctrl_a),
    .stall_cnt(stall_cnt_a));

  pipe_stage_reg #(.DATA_W(16), .NUM_DATA(2), .CTRL_W(3), .SKID(0), .NOP_IR(16'hF000), .CNT_W(4)) dut_b (
    .clk(clk), .reset(reset), .flush(flush_b), .in_valid(in_valid_b), .in_ready(in_ready_b),
    .in_ir(in_ir_b), .in_data(in_data_b), .in_ctrl(in_ctrl_b), .out_valid(out_valid_b),
    .out_ready(out_ready_b), .out_ir(out_ir_b), .out_data(out_data_b), .out_ctrl(out_ctrl_b),
    .stall_cnt(stall_cnt_b));

  typedef struct packed {
    logic [15:0] ir;
    logic [31:0] data;
    logic [2:0]  ctrl;
  } ent_t;

  ent_t qa[$];
  ent_t qb[$];
  int   sa, sb;
  bit   live;
  int   tests, fails;

  task automatic idle();
    flush_a = 0; in_valid_a = 0; out_ready_a = 1; in_ir_a = '0; in_data_a = '0; in_ctrl_a = 0;
    flush_b = 0; in_valid_b = 0; out_ready_b = 1; in_ir_b = '0; in_data_b = '0; in_ctrl_b = '0;
  endtask

  // One clock cycle: model advances from the pre-edge inputs, returns at the next negedge.
  task automatic step();
    bit acc_a, fire_a, acc_b, fire_b;
    ent_t e;
    acc_a  = in_valid_a && live && (qa.size() < 2);
    fire_a = (qa.size() > 0) && out_ready_a;
    acc_b  = in_valid_b && live && ((qb.size() == 0) || out_ready_b);
    fire_b = (qb.size() > 0) && out_ready_b;
    if (qa.size() > 0 && !out_ready_a && sa < 255) sa++;
    if (qb.size() > 0 && !out_ready_b && sb < 15) sb++;
    @(posedge clk);
    if (flush_a) qa.delete();
    else begin
      if (fire_a) void'(qa.pop_front());
      if (acc_a) begin
        e.ir = in_ir_a; e.data = {16'h0, in_data_a}; e.ctrl = {2'b00, in_ctrl_a};
        qa.push_back(e);
      end
    end
    if (flush_b) qb.delete();
    else begin
      if (fire_b) void'(qb.pop_front());
      if (acc_b) begin
        e.ir = in_ir_b; e.data = in_data_b; e.ctrl = in_ctrl_b;
        qb.push_back(e);
      end
    end
    live = (reset === 1'b1);
    @(negedge clk);
  endtask

  task automatic do_reset();
    reset = 0;
    qa.delete(); qb.delete(); sa = 0; sb = 0; live = 0;
    idle();
    @(negedge clk);
    @(negedge clk);
    reset = 1;
    step();
  endtask

  task automatic test_reset();
    do_reset();
    tests++;
    if (in_ready_a !== 1'b1) begin fails++; $display("FAIL reset_in_ready_a: got %b expected 1", in_ready_a); end
    tests++;
    if (in_ready_b !== 1'b1) begin fails++; $display("FAIL reset_in_ready_b: got %b expected 1", in_ready_b); end
    // Leave a pending skid entry and a stall count, then reset mid-cycle.
    in_valid_a = 1; out_ready_a = 0; in_ir_a = 16'h0A01; in_ctrl_a = 1; in_data_a = 16'h1234;
    in_valid_b = 1; out_ready_b = 0; in_ir_b = 16'h0B01; in_ctrl_b = 3'd5; in_data_b = 32'hCAFE_BEEF;
    step(); in_ir_a = 16'h0A02; step(); step();
    #2 reset = 0;
    #1;
    tests++;
    if (out_valid_a !== 1'b0 || out_ir_a !== 16'hF000 || out_ctrl_a !== 1'b0 || out_data_a !== 16'h0)
      begin fails++; $display("FAIL reset_out_a: got v=%b ir=%h c=%b d=%h expected v=0 ir=f000 c=0 d=0000", out_valid_a, out_ir_a, out_ctrl_a, out_data_a); end
    tests++;
    if (stall_cnt_a !== 8'd0) begin fails++; $display("FAIL reset_stall_a: got %0d expected 0", stall_cnt_a); end
    tests++;
    if (out_valid_b !== 1'b0 || out_ir_b !== 16'hF000 || out_ctrl_b !== 3'd0 || stall_cnt_b !== 4'd0)
      begin fails++; $display("FAIL reset_out_b: got v=%b ir=%h c=%h cnt=%0d expected v=0 ir=f000 c=0 cnt=0", out_valid_b, out_ir_b, out_ctrl_b, stall_cnt_b); end
    do_reset();
    step();
    tests++;
    if (out_valid_a !== 1'b0 || in_ready_a !== 1'b1)
      begin fails++; $display("FAIL reset_skid_cleared: got v=%b rdy=%b expected v=0 rdy=1", out_valid_a, in_ready_a); end
  endtask

  task automatic test_streaming();
    logic [15:0] d [0:7];
    idle();
    for (int i = 0; i <= 8; i++) begin
      in_valid_a = (i < 8);
      in_ir_a    = 16'h1001 + 16'(i);
      in_data_a  = 16'($urandom);
      in_ctrl_a  = 1'($urandom);
      if (i < 8) d[i] = in_data_a;
      step();
      tests++;
      if (i < 8) begin
        if (out_valid_a !== 1'b1 || out_ir_a !== 16'h1001 + 16'(i) || out_data_a !== d[i] || in_ready_a !== 1'b1)
          begin fails++; $display("FAIL stream_%0d: got v=%b ir=%h d=%h rdy=%b expected v=1 ir=%h d=%h rdy=1", i, out_valid_a, out_ir_a, out_data_a, in_ready_a, 16'h1001 + 16'(i), d[i]); end
      end else begin
        if (out_valid_a !== 1'b0 || out_ir_a !== 16'hF000)
          begin fails++; $display("FAIL stream_drain: got v=%b ir=%h expected v=0 ir=f000", out_valid_a, out_ir_a); end
      end
    end
  endtask

  task automatic test_skid();
    logic [15:0] exp_ir [0:5];
    logic        exp_v [0:5], exp_rdy [0:5];
    int          exp_cnt [0:5];
    exp_ir  = '{16'h2001, 16'h2001, 16'h2001, 16'h2001, 16'h2002, 16'hF000};
    exp_v   = '{1, 1, 1, 1, 1, 0};
    exp_rdy = '{1, 0, 0, 0, 1, 1};
    exp_cnt = '{0, 1, 2, 3, 3, 3};
    do_reset();
    for (int i = 0; i < 6; i++) begin
      in_valid_a  = (i < 2);
      in_ir_a     = (i == 0) ? 16'h2001 : 16'h2002;
      out_ready_a = (i >= 4);
      step();
      tests++;
      if (out_valid_a !== exp_v[i] || out_ir_a !== exp_ir[i] || in_ready_a !== exp_rdy[i] || stall_cnt_a !== 8'(exp_cnt[i]))
        begin fails++; $display("FAIL skid_%0d: got v=%b ir=%h rdy=%b cnt=%0d expected v=%b ir=%h rdy=%b cnt=%0d", i, out_valid_a, out_ir_a, in_ready_a, stall_cnt_a, exp_v[i], exp_ir[i], exp_rdy[i], exp_cnt[i]); end
    end
  endtask

  task automatic test_flush();
    idle();
    in_valid_a = 1; out_ready_a = 0; in_ir_a = 16'h3001; step();
    in_ir_a = 16'h3002; step();
    tests++;
    if (in_ready_a !== 1'b0) begin fails++; $display("FAIL flush_setup_full: got rdy=%b expected 0", in_ready_a); end
    flush_a = 1; in_ir_a = 16'h3003; step();
    flush_a = 0; in_valid_a = 0;
    tests++;
    if (out_valid_a !== 1'b0 || out_ir_a !== 16'hF000 || out_ctrl_a !== 1'b0 || in_ready_a !== 1'b1)
      begin fails++; $display("FAIL flush_full: got v=%b ir=%h c=%b rdy=%b expected v=0 ir=f000 c=0 rdy=1", out_valid_a, out_ir_a, out_ctrl_a, in_ready_a); end
    out_ready_a = 1; step();
    tests++;
    if (out_valid_a !== 1'b0) begin fails++; $display("FAIL flush_residue: got v=%b ir=%h expected v=0", out_valid_a, out_ir_a); end
    in_valid_a = 1; flush_a = 1; in_ir_a = 16'h3004; in_ctrl_a = 1; step();
    flush_a = 0; in_valid_a = 0;
    tests++;
    if (out_valid_a !== 1'b0 || out_ir_a !== 16'hF000 || out_ctrl_a !== 1'b0)
      begin fails++; $display("FAIL flush_accept_dropped: got v=%b ir=%h c=%b expected v=0 ir=f000 c=0", out_valid_a, out_ir_a, out_ctrl_a); end
  endtask

  task automatic test_random_a();
    logic        ev;
    logic [15:0] eir;
    idle();
    for (int i = 0; i < 400; i++) begin
      in_valid_a  = ($urandom_range(3) != 0);
      out_ready_a = ($urandom_range(9) < 7);
      flush_a     = ($urandom_range(31) == 0);
      in_ir_a     = 16'($urandom);
      in_data_a   = 16'($urandom);
      in_ctrl_a   = 1'($urandom);
      step();
      ev  = (qa.size() > 0);
      eir = ev ? qa[0].ir : 16'hF000;
      tests++;
      if (out_valid_a !== ev || out_ir_a !== eir || out_ctrl_a !== (ev ? qa[0].ctrl[0] : 1'b0) ||
          (ev && out_data_a !== qa[0].data[15:0]))
        begin fails++; $display("FAIL rand_a_out_%0d: got v=%b ir=%h c=%b d=%h expected v=%b ir=%h", i, out_valid_a, out_ir_a, out_ctrl_a, out_data_a, ev, eir); end
      tests++;
      if (in_ready_a !== (qa.size() < 2) || stall_cnt_a !== 8'(sa))
        begin fails++; $display("FAIL rand_a_ctl_%0d: got rdy=%b cnt=%0d expected rdy=%b cnt=%0d", i, in_ready_a, stall_cnt_a, (qa.size() < 2), sa); end
    end
  endtask

  task automatic test_saturation();
    do_reset();
    in_valid_b = 1; out_ready_b = 0; in_ir_b = 16'h4001; in_data_b = 32'h1111_2222; in_ctrl_b = 3'd6;
    step();
    in_valid_b = 0;
    for (int i = 0; i < 20; i++) begin
      step();
      if (i == 9) begin
        tests++;
        if (stall_cnt_b !== 4'd10) begin fails++; $display("FAIL sat_mid: got %0d expected 10", stall_cnt_b); end
      end
    end
    tests++;
    if (stall_cnt_b !== 4'd15 || stall_cnt_b !== 4'(sb))
      begin fails++; $display("FAIL sat_final: got %0d expected 15", stall_cnt_b); end
    tests++;
    if (out_valid_b !== 1'b1 || out_ir_b !== 16'h4001 || out_data_b !== 32'h1111_2222 || out_ctrl_b !== 3'd6)
      begin fails++; $display("FAIL sat_hold: got v=%b ir=%h d=%h c=%h expected v=1 ir=4001 d=11112222 c=6", out_valid_b, out_ir_b, out_data_b, out_ctrl_b); end
  endtask

  task automatic test_skid0();
    logic        ev, er;
    logic [15:0] eir;
    idle();
    for (int i = 0; i < 300; i++) begin
      in_valid_b  = ($urandom_range(3) != 0);
      out_ready_b = (i % 2 == 1) ^ ($urandom_range(7) == 0);
      flush_b     = ($urandom_range(39) == 0);
      in_ir_b     = 16'($urandom);
      in_data_b   = $urandom;
      in_ctrl_b   = 3'($urandom);
      #1;
      er = (qb.size() == 0) || out_ready_b;
      tests++;
      if (in_ready_b !== er) begin fails++; $display("FAIL skid0_rdy_%0d: got %b expected %b", i, in_ready_b, er); end
      step();
      ev  = (qb.size() > 0);
      eir = ev ? qb[0].ir : 16'hF000;
      tests++;
      if (out_valid_b !== ev || out_ir_b !== eir || out_ctrl_b !== (ev ? qb[0].ctrl : 3'd0) ||
          (ev && out_data_b !== qb[0].data) || stall_cnt_b !== 4'(sb))
        begin fails++; $display("FAIL skid0_out_%0d: got v=%b ir=%h c=%h d=%h cnt=%0d expected v=%b ir=%h cnt=%0d", i, out_valid_b, out_ir_b, out_ctrl_b, out_data_b, stall_cnt_b, ev, eir, sb); end
    end
  endtask

  initial begin
    tests = 0; fails = 0; live = 0; reset = 0;
    idle();
    test_reset();
    test_streaming();
    test_skid();
    test_flush();
    test_random_a();
    test_saturation();
    test_skid0();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
